// File: rtl/yc_noc_defs.sv
// rtl/yc_noc_defs.sv - flit type and destination accessors for the yc NoC
package yc_noc_defs;

  typedef struct packed {
    logic [3:0]  dst_x;
    logic [3:0]  dst_y;
    logic [3:0]  src;
    logic [7:0]  seq;
    logic [11:0] data;
  } flit_t;

  function automatic logic [3:0] get_dst_x(flit_t f);
    return f.dst_x;
  endfunction

  function automatic logic [3:0] get_dst_y(flit_t f);
    return f.dst_y;
  endfunction

endpackage

// File: rtl/yc_router.sv
// rtl/yc_router.sv - five-port XY mesh router with per-input FIFOs and round-robin outputs
module yc_router
  import yc_noc_defs::*;
#(
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  n_in_valid,
  input  flit_t n_in_flit,
  output logic  n_in_ready,
  input  logic  e_in_valid,
  input  flit_t e_in_flit,
  output logic  e_in_ready,
  input  logic  s_in_valid,
  input  flit_t s_in_flit,
  output logic  s_in_ready,
  input  logic  w_in_valid,
  input  flit_t w_in_flit,
  output logic  w_in_ready,
  input  logic  l_in_valid,
  input  flit_t l_in_flit,
  output logic  l_in_ready,
  output logic  n_out_valid,
  output flit_t n_out_flit,
  input  logic  n_out_ready,
  output logic  e_out_valid,
  output flit_t e_out_flit,
  input  logic  e_out_ready,
  output logic  s_out_valid,
  output flit_t s_out_flit,
  input  logic  s_out_ready,
  output logic  w_out_valid,
  output flit_t w_out_flit,
  input  logic  w_out_ready,
  output logic  l_out_valid,
  output flit_t l_out_flit,
  input  logic  l_out_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] MY_X = 4'(X_ID);
  localparam logic [3:0] MY_Y = 4'(Y_ID);
  localparam logic [2:0] P_N = 3'd0, P_E = 3'd1, P_S = 3'd2, P_W = 3'd3, P_L = 3'd4;

  logic       in_valid  [5];
  flit_t      in_flit   [5];
  logic       in_ready  [5];
  logic       out_ready [5];
  logic       out_valid [5];
  flit_t      out_flit  [5];
  flit_t      head      [5];
  logic       empty     [5];
  logic [2:0] route     [5];
  logic       pop       [5];
  logic [4:0] gnt       [5];

  assign in_valid  = '{n_in_valid, e_in_valid, s_in_valid, w_in_valid, l_in_valid};
  assign in_flit   = '{n_in_flit, e_in_flit, s_in_flit, w_in_flit, l_in_flit};
  assign out_ready = '{n_out_ready, e_out_ready, s_out_ready, w_out_ready, l_out_ready};

  assign n_in_ready = in_ready[0];
  assign e_in_ready = in_ready[1];
  assign s_in_ready = in_ready[2];
  assign w_in_ready = in_ready[3];
  assign l_in_ready = in_ready[4];

  assign n_out_valid = out_valid[0];
  assign e_out_valid = out_valid[1];
  assign s_out_valid = out_valid[2];
  assign w_out_valid = out_valid[3];
  assign l_out_valid = out_valid[4];
  assign n_out_flit  = out_flit[0];
  assign e_out_flit  = out_flit[1];
  assign s_out_flit  = out_flit[2];
  assign w_out_flit  = out_flit[3];
  assign l_out_flit  = out_flit[4];

  // An input is granted by at most one output, since its head requests exactly one.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      pop[i] = 1'b0;
      for (int o = 0; o < 5; o++) pop[i] = pop[i] | gnt[o][i];
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_in
    flit_t         mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;

    assign in_ready[i] = (count != CW'(FIFO_DEPTH)) && !rst;
    assign push        = in_valid[i] && in_ready[i];
    assign empty[i]    = (count == '0);
    assign head[i]     = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)   wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop[i]) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        if (push && !pop[i])      count <= count + 1'b1;
        else if (!push && pop[i]) count <= count - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_flit[i];
    end

    // XY dimension order: resolve X fully before looking at Y.
    always_comb begin
      if (get_dst_x(head[i]) > MY_X)      route[i] = P_E;
      else if (get_dst_x(head[i]) < MY_X) route[i] = P_W;
      else if (get_dst_y(head[i]) > MY_Y) route[i] = P_S;
      else if (get_dst_y(head[i]) < MY_Y) route[i] = P_N;
      else                                route[i] = P_L;
    end
  end

  for (genvar o = 0; o < 5; o++) begin : g_out
    logic [2:0] rr_ptr;
    logic [2:0] win;
    logic [2:0] idx;
    logic [3:0] sum;
    logic [4:0] req;
    logic       any;
    logic       grant;
    logic       ov_q;
    flit_t      of_q;

    always_comb begin
      for (int i = 0; i < 5; i++) req[i] = !empty[i] && (route[i] == 3'(o));
    end

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
      any = 1'b0;
      win = rr_ptr;
      sum = 4'd0;
      idx = 3'd0;
      for (int k = 4; k >= 0; k--) begin
        sum = {1'b0, rr_ptr} + 4'(k);
        idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
        if (req[idx]) begin
          any = 1'b1;
          win = idx;
        end
      end
    end

    assign grant     = any && (!ov_q || out_ready[o]);
    assign gnt[o]    = grant ? (5'b00001 << win) : 5'b00000;
    assign out_valid[o] = ov_q;
    assign out_flit[o]  = of_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ov_q   <= 1'b0;
        of_q   <= '0;
        rr_ptr <= 3'd0;
      end else if (grant) begin
        ov_q   <= 1'b1;
        of_q   <= head[win];
        rr_ptr <= (win == 3'd4) ? 3'd0 : win + 3'd1;
      end else if (out_ready[o]) begin
        ov_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_yc_router.sv
// tb/tb_yc_router.sv - scoreboard bench for yc_router placed at mesh node (1,1)
module tb_yc_router;
  import yc_noc_defs::*;

  localparam int DEPTH = 2;

  logic  clk = 1'b0;
  logic  rst;
  logic  iv   [5];
  flit_t ifl  [5];
  logic  ird  [5];
  logic  ov   [5];
  flit_t ofl  [5];
  logic  ordy [5];

  int    checks = 0;
  int    errors = 0;
  flit_t exp_q [5][$];
  int    deliv_e [16];
  int    accepted [5];
  int    stalls [5];
  flit_t mon_e;

  always #5 clk = ~clk;

  yc_router #(.X_ID(1), .Y_ID(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .n_in_valid(iv[0]), .n_in_flit(ifl[0]), .n_in_ready(ird[0]),
    .e_in_valid(iv[1]), .e_in_flit(ifl[1]), .e_in_ready(ird[1]),
    .s_in_valid(iv[2]), .s_in_flit(ifl[2]), .s_in_ready(ird[2]),
    .w_in_valid(iv[3]), .w_in_flit(ifl[3]), .w_in_ready(ird[3]),
    .l_in_valid(iv[4]), .l_in_flit(ifl[4]), .l_in_ready(ird[4]),
    .n_out_valid(ov[0]), .n_out_flit(ofl[0]), .n_out_ready(ordy[0]),
    .e_out_valid(ov[1]), .e_out_flit(ofl[1]), .e_out_ready(ordy[1]),
    .s_out_valid(ov[2]), .s_out_flit(ofl[2]), .s_out_ready(ordy[2]),
    .w_out_valid(ov[3]), .w_out_flit(ofl[3]), .w_out_ready(ordy[3]),
    .l_out_valid(ov[4]), .l_out_flit(ofl[4]), .l_out_ready(ordy[4])
  );

  function automatic flit_t mk(int dx, int dy, int s, int q);
    flit_t f;
    f.dst_x = 4'(dx);
    f.dst_y = 4'(dy);
    f.src   = 4'(s);
    f.seq   = 8'(q);
    f.data  = 12'(q * 5 + s + 12'h3a0);
    return f;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input int p, input flit_t f, input int exp_port);
    int waited;
    waited = 0;
    iv[p]  = 1'b1;
    ifl[p] = f;
    forever begin
      @(negedge clk);
      if (ird[p]) break;
      stalls[p]++;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout port %0d: got in_ready 0 expected 1", p);
        iv[p] = 1'b0;
        return;
      end
    end
    if (exp_port >= 0) exp_q[exp_port].push_back(f);
    @(posedge clk);
    #1;
    iv[p] = 1'b0;
    accepted[p]++;
  endtask

  task automatic wait_drain(string name);
    int left;
    for (int c = 0; c < 200; c++) begin
      left = 0;
      for (int o = 0; o < 5; o++) left += exp_q[o].size();
      if (left == 0) break;
      @(negedge clk);
    end
    check(name, 32'(left), 32'd0);
  endtask

  // Monitor: every flit that will transfer on the next edge is compared with its queue head.
  always @(negedge clk) begin
    if (!rst) begin
      for (int o = 0; o < 5; o++) begin
        if (ov[o] && ordy[o]) begin
          checks++;
          if (exp_q[o].size() == 0) begin
            errors++;
            $display("FAIL unexpected_flit port %0d: got %0h expected none", o, ofl[o]);
          end else begin
            mon_e = exp_q[o].pop_front();
            if (ofl[o] !== mon_e) begin
              errors++;
              $display("FAIL flit_port%0d: got %0h expected %0h", o, ofl[o], mon_e);
            end
          end
          if (o == 1) deliv_e[int'(ofl[o].src)]++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    flit_t f, fa, fb, fx, fy, first;
    int mx, mn;
    rst = 1'b1;
    for (int p = 0; p < 5; p++) begin
      iv[p] = 1'b0; ifl[p] = '0; ordy[p] = 1'b1; accepted[p] = 0; stalls[p] = 0;
    end
    for (int s = 0; s < 16; s++) deliv_e[s] = 0;

    repeat (2) @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      check($sformatf("rst_out_valid%0d", p), 32'(ov[p]), 32'd0);
      check($sformatf("rst_in_ready%0d", p), 32'(ird[p]), 32'd0);
      check($sformatf("rst_out_flit%0d", p), ofl[p], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 5; p++) check($sformatf("rel_in_ready%0d", p), 32'(ird[p]), 32'd1);

    // Latency: accepted at edge t, visible after edge t+1, on E only.
    @(posedge clk); #1;
    f = mk(2, 1, 4, 1);
    send(4, f, 1);
    @(negedge clk);
    check("lat_e_valid_t", 32'(ov[1]), 32'd0);
    @(negedge clk);
    check("lat_e_valid_t1", 32'(ov[1]), 32'd1);
    check("lat_e_flit", ofl[1], f);
    check("lat_others", 32'({ov[0], ov[2], ov[3], ov[4]}), 32'd0);
    wait_drain("drain_lat");

    // One flit to each direction from the local port.
    @(posedge clk); #1;
    send(4, mk(2, 1, 4, 2), 1);
    send(4, mk(0, 1, 4, 3), 3);
    send(4, mk(1, 2, 4, 4), 2);
    send(4, mk(1, 0, 4, 5), 0);
    send(4, mk(1, 1, 4, 6), 4);
    wait_drain("drain_dirs");

    // Fairness: N, S, L to E staggered by one cycle; grants must rotate N, S, L.
    for (int s = 0; s < 16; s++) deliv_e[s] = 0;
    for (int k = 0; k < 90; k++)
      exp_q[1].push_back(mk(2, 1, (k % 3) * 2, 100 + k / 3));
    @(posedge clk); #1;
    fork
      begin
        for (int j = 0; j < 30; j++) send(0, mk(2, 1, 0, 100 + j), -1);
      end
      begin
        @(posedge clk); #1;
        for (int j = 0; j < 30; j++) send(2, mk(2, 1, 2, 100 + j), -1);
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        for (int j = 0; j < 30; j++) send(4, mk(2, 1, 4, 100 + j), -1);
      end
    join
    wait_drain("drain_fair");
    check("fair_n", 32'(deliv_e[0]), 32'd30);
    check("fair_s", 32'(deliv_e[2]), 32'd30);
    check("fair_l", 32'(deliv_e[4]), 32'd30);
    mx = deliv_e[0]; mn = deliv_e[0];
    for (int s = 2; s <= 4; s += 2) begin
      if (deliv_e[s] > mx) mx = deliv_e[s];
      if (deliv_e[s] < mn) mn = deliv_e[s];
    end
    check("fair_spread", 32'(mx - mn <= 1), 32'd1);

    // Backpressure on E while L streams.
    ordy[1] = 1'b0;
    accepted[4] = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int j = 0; j < 6; j++) send(4, mk(2, 1, 4, 50 + j), 1);
      end
      begin
        for (int c = 0; c < 20 && !ov[1]; c++) @(negedge clk);
        check("bp_valid_seen", 32'(ov[1]), 32'd1);
        first = ofl[1];
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("bp_flit_stable", ofl[1], first);
          check("bp_valid_stable", 32'(ov[1]), 32'd1);
        end
        check("bp_accepted", 32'(accepted[4]), 32'(DEPTH + 1));
        check("bp_in_ready_low", 32'(ird[4]), 32'd0);
        ordy[1] = 1'b1;
      end
    join
    wait_drain("drain_bp");

    // Concurrent N->E and L->W must never stall either input.
    stalls[0] = 0;
    stalls[4] = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int j = 0; j < 8; j++) send(0, mk(2, 1, 0, 70 + j), 1);
      end
      begin
        for (int j = 0; j < 8; j++) send(4, mk(0, 1, 4, 80 + j), 3);
      end
    join
    check("conc_stall_n", 32'(stalls[0]), 32'd0);
    check("conc_stall_l", 32'(stalls[4]), 32'd0);
    wait_drain("drain_conc");

    // Mid-stream reset: W->E leaves E's rr_ptr at L, then reset must bring it back to N.
    @(posedge clk); #1;
    fa = mk(2, 1, 3, 90);
    fb = mk(2, 1, 3, 91);
    send(3, fa, 1);
    send(3, fb, 1);
    #1;
    check("mid_valid_before_rst", 32'(ov[1]), 32'd1);
    rst = 1'b1;
    #1;
    for (int p = 0; p < 5; p++) check($sformatf("mid_rst_out_valid%0d", p), 32'(ov[p]), 32'd0);
    for (int o = 0; o < 5; o++) exp_q[o].delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int p = 0; p < 5; p++) check($sformatf("post_rst_idle%0d", p), 32'(ov[p]), 32'd0);
    fx = mk(2, 1, 0, 95);
    fy = mk(2, 1, 4, 96);
    exp_q[1].push_back(fx);
    exp_q[1].push_back(fy);
    @(posedge clk); #1;
    fork
      send(0, fx, -1);
      send(4, fy, -1);
    join
    wait_drain("drain_after_rst");

    repeat (3) @(negedge clk);
    for (int o = 0; o < 5; o++) check($sformatf("final_queue%0d", o), 32'(exp_q[o].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
